// File: rtl/moving_average_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : moving_average_filter                                      |
// | Description : Boxcar filter, rounded mean of the last 2**LOG2_LEN samples |
// |               with a history-clearing sequencer.                          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module moving_average_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_LEN   = 4
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         clear_i,
  input  logic                         sample_valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         ready_o,
  output logic                         drop_o
);

  localparam int c_LEN   = 1 << LOG2_LEN;
  localparam int c_ACC_W = DATA_WIDTH + LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] c_PTR_LAST = '1;
  localparam logic signed [c_ACC_W:0] c_HALF = {{c_ACC_W{1'b0}}, 1'b1} << (LOG2_LEN - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic        [LOG2_LEN-1:0]     r_ptr;
  logic signed [DATA_WIDTH-1:0]   r_buf [c_LEN];
  logic signed [DATA_WIDTH-1:0]   r_s1_x;
  logic signed [DATA_WIDTH-1:0]   r_s1_old;
  logic                           r_s1_v;
  logic                           r_s2_v;
  logic signed [c_ACC_W-1:0]      r_acc;
  logic signed [c_ACC_W:0]        w_sum;
  logic signed [DATA_WIDTH-1:0]   r_data;
  logic                           r_data_valid;
  logic                           r_drop;
  logic                           w_accept;
  logic                           w_clearing;
  logic                           w_buf_we;
  logic signed [DATA_WIDTH-1:0]   w_buf_wd;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (!clear_i && (r_ptr == c_PTR_LAST)) w_state_nxt = ST_RUN;
      ST_RUN:   if (clear_i) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign ready_o    = (r_state == ST_RUN);
  assign w_clearing = (r_state == ST_CLEAR);
  // A clear request in the same cycle as a sample always wins.
  assign w_accept   = ready_o & sample_valid_i & ~clear_i;
  assign w_buf_we   = w_accept | w_clearing;
  assign w_buf_wd   = w_clearing ? '0 : data_i;
  assign w_sum      = {r_acc[c_ACC_W-1], r_acc} + c_HALF;

  always_ff @(posedge clk_i) begin
    if (w_buf_we) begin
      r_buf[r_ptr] <= w_buf_wd;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_ptr        <= '0;
      r_s1_x       <= '0;
      r_s1_old     <= '0;
      r_s1_v       <= 1'b0;
      r_s2_v       <= 1'b0;
      r_acc        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= sample_valid_i & (~ready_o | clear_i);

      if (clear_i) begin
        r_ptr <= '0;
      end else if (w_buf_we) begin
        r_ptr <= r_ptr + 1'b1;
      end

      // Read-before-write: the sample leaving the window is captured here.
      if (w_accept) begin
        r_s1_x   <= data_i;
        r_s1_old <= r_buf[r_ptr];
      end

      if (clear_i || w_clearing) begin
        r_s1_v       <= 1'b0;
        r_s2_v       <= 1'b0;
        r_acc        <= '0;
        r_data_valid <= 1'b0;
      end else begin
        r_s1_v       <= w_accept;
        r_s2_v       <= r_s1_v;
        r_data_valid <= r_s2_v;
        if (r_s1_v) begin
          r_acc <= r_acc + {{LOG2_LEN{r_s1_x[DATA_WIDTH-1]}}, r_s1_x}
                         - {{LOG2_LEN{r_s1_old[DATA_WIDTH-1]}}, r_s1_old};
        end
        if (r_s2_v) begin
          r_data <= DATA_WIDTH'(w_sum >>> LOG2_LEN);
        end
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_data_valid;
  assign drop_o       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_moving_average_filter.sv
`default_nettype none
// Bench for moving_average_filter: directed steps, window-sum reference model
// and an expected-output queue checked on every data_valid_o strobe.
module tb_moving_average_filter;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = 1 << L;

  logic                clk_i = 1'b0;
  logic                arstn_i = 1'b0;
  logic                clear_i = 1'b0;
  logic                sample_valid_i = 1'b0;
  logic signed [W-1:0] data_i = '0;
  logic signed [W-1:0] data_o;
  logic                data_valid_o;
  logic                ready_o;
  logic                drop_o;

  moving_average_filter #(.DATA_WIDTH(W), .LOG2_LEN(L)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .clear_i        (clear_i),
    .sample_valid_i (sample_valid_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .ready_o        (ready_o),
    .drop_o         (drop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int     val;
    longint due;
  } exp_t;

  exp_t   q[$];
  int     hist[N];
  int     mptr = 0;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expd);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) hist[i] = 0;
    mptr = 0;
  endtask

  // Reference: rounded mean of the whole window, recomputed from scratch.
  task automatic model_push(input int v);
    int   sum;
    exp_t e;
    hist[mptr] = v;
    mptr = (mptr + 1) % N;
    sum = 0;
    for (int i = 0; i < N; i++) sum += hist[i];
    e.val = (sum + N / 2) >>> L;
    e.due = cyc + 3;
    q.push_back(e);
  endtask

  // mode 0: expect rejection, 1: accepted with output, 2: accepted, output cancelled
  task automatic send(input int v, input bit exp_drop, input int mode);
    data_i = W'(v);
    sample_valid_i = 1'b1;
    if (mode == 1) model_push(v);
    @(negedge clk_i);
    sample_valid_i = 1'b0;
    check("drop_o", drop_o, exp_drop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arstn_i = 1'b0;
    idle(2);
    q.delete();
    model_clear();
    arstn_i = 1'b1;
    idle(N);
    check("ready_after_clear", ready_o, 1);
  endtask

  always @(negedge clk_i) begin
    if (arstn_i && data_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data_o", $signed(data_o), e.val);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    model_clear();
    #1;
    check("rst_data_o", $signed(data_o), 0);
    check("rst_valid", data_valid_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_drop", drop_o, 0);
    idle(2);
    arstn_i = 1'b1;

    // Samples offered during the clear sweep are all dropped.
    for (int i = 0; i < N; i++) begin
      check("ready_in_clear", ready_o, 0);
      send(5000 + i, 1'b1, 0);
    end
    check("ready_after_sweep", ready_o, 1);
    send(160, 1'b0, 1);
    wait_drain();

    // Step response to +1000 at one sample per four clocks.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(1000, 1'b0, 1);
      idle(3);
    end
    for (int i = 0; i < 16; i++) begin
      send(-1000, 1'b0, 1);
      idle(3);
    end
    wait_drain();

    do_reset();
    send(-1000, 1'b0, 1);
    wait_drain();

    // Full-scale back-to-back stream.
    do_reset();
    for (int i = 0; i < 16; i++) send(32767, 1'b0, 1);
    for (int i = 0; i < 16; i++) send(-32768, 1'b0, 1);
    wait_drain();

    // Clear with two samples still in the pipeline.
    do_reset();
    for (int i = 0; i < 6; i++) send(1000, 1'b0, 1);
    wait_drain();
    send(2000, 1'b0, 2);
    send(3000, 1'b0, 2);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) begin
      check("ready_during_clear", ready_o, 0);
      @(negedge clk_i);
    end
    check("ready_after_clear_req", ready_o, 1);
    send(1000, 1'b0, 1);
    wait_drain();

    // clear_i coincident with a sample: clear wins.
    clear_i = 1'b1;
    send(777, 1'b1, 0);
    clear_i = 1'b0;
    model_clear();
    idle(N);
    check("ready_after_coincident", ready_o, 1);

    // Random stream with random gaps.
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(65535)) - 32768, 1'b0, 1);
      idle(int'($urandom_range(2)));
    end
    wait_drain();

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 20; i++) send(1000, 1'b0, 1);
    @(posedge clk_i);
    #1;
    check("pre_reset_valid", data_valid_o, 1);
    check("pre_reset_data", $signed(data_o), 1000);
    #1;
    arstn_i = 1'b0;
    #1;
    check("async_data_o", $signed(data_o), 0);
    check("async_valid", data_valid_o, 0);
    check("async_ready", ready_o, 0);
    check("async_drop", drop_o, 0);
    q.delete();
    model_clear();
    @(negedge clk_i);
    arstn_i = 1'b1;
    idle(N);
    check("ready_after_async", ready_o, 1);
    send(1000, 1'b0, 1);
    wait_drain();

    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
